// File: rtl/mapa_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mapa_pkg                                                     |
// | Purpose  : Shared constants, tile ids, FSM encoding and helpers for     |
// |            the tile-map store (grid geometry, palette, cell addressing).|
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package mapa_pkg;

   localparam int SCREEN_WIDTH  = 640;
   localparam int SCREEN_HEIGHT = 480;
   localparam int BLOCK_BITS    = 4;
   localparam int BLOCK_SIZE    = 1 << BLOCK_BITS;

   localparam int GRID_W = SCREEN_WIDTH / BLOCK_SIZE;   // 40 columns
   localparam int GRID_H = SCREEN_HEIGHT / BLOCK_SIZE;  // 30 rows
   localparam int CELLS  = GRID_W * GRID_H;             // 1200 cells

   localparam int ADDR_W   = 11;
   localparam int COORD_W  = 10;
   localparam int TILE_W   = 3;
   localparam int COLOUR_W = 6;

   // Sized copies so comparisons against coordinate ports stay width-clean.
   localparam logic [COORD_W-1:0] GRID_W_C  = COORD_W'(GRID_W);
   localparam logic [COORD_W-1:0] GRID_H_C  = COORD_W'(GRID_H);
   localparam logic [ADDR_W-1:0]  LAST_CELL = ADDR_W'(CELLS - 1);
   localparam logic [5:0]         LAST_COL  = 6'(GRID_W - 1);
   localparam logic [4:0]         LAST_ROW  = 5'(GRID_H - 1);

   localparam logic [TILE_W-1:0] TILE_EMPTY  = 3'd0;
   localparam logic [TILE_W-1:0] TILE_WALL   = 3'd1;
   localparam logic [TILE_W-1:0] TILE_PLAYER = 3'd2;
   localparam logic [TILE_W-1:0] TILE_ENEMY  = 3'd3;
   localparam logic [TILE_W-1:0] TILE_ITEM   = 3'd4;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Fixed palette, packed as {R[1:0], G[1:0], B[1:0]}.
   function automatic logic [COLOUR_W-1:0] tile_colour(input logic [TILE_W-1:0] tile);
      logic [COLOUR_W-1:0] c;
      case (tile)
         3'd0:    c = 6'b00_00_00;
         3'd1:    c = 6'b10_10_10;
         3'd2:    c = 6'b00_11_00;
         3'd3:    c = 6'b11_00_00;
         3'd4:    c = 6'b11_11_00;
         3'd5:    c = 6'b00_00_11;
         3'd6:    c = 6'b11_00_11;
         default: c = 6'b11_11_11;
      endcase
      return c;
   endfunction

   // Row-major cell index y*40 + x as shift-and-add. Callers only pass
   // in-range coordinates, so the truncated operands are sufficient.
   function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] x, input logic [4:0] y);
      logic [ADDR_W-1:0] ye;
      ye = ADDR_W'(y);
      return (ye << 5) + (ye << 3) + ADDR_W'(x);
   endfunction

   function automatic logic coord_in_range(input logic [COORD_W-1:0] x,
                                           input logic [COORD_W-1:0] y);
      return (x < GRID_W_C) && (y < GRID_H_C);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mapa_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mapa_if                                                      |
// | Purpose  : Renderer read port and game-logic write port of the map.     |
// |            master = renderer/game side, slave = mapa.                   |
// | Ports    : renderer_rx/ry, mapa_read -> colour mapa_R/G/B (1 cycle);    |
// |            wr_en, wr_x/y, wr_tile -> write; wr_ready, busy status.      |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
interface mapa_if;
   import mapa_pkg::*;

   logic [COORD_W-1:0] renderer_rx;
   logic [COORD_W-1:0] renderer_ry;
   logic               mapa_read;
   logic [1:0]         mapa_R;
   logic [1:0]         mapa_G;
   logic [1:0]         mapa_B;
   logic               wr_en;
   logic [COORD_W-1:0] wr_x;
   logic [COORD_W-1:0] wr_y;
   logic [TILE_W-1:0]  wr_tile;
   logic               wr_ready;
   logic               busy;

   modport master (
      output renderer_rx, renderer_ry, mapa_read, wr_en, wr_x, wr_y, wr_tile,
      input  mapa_R, mapa_G, mapa_B, wr_ready, busy
   );

   modport slave (
      input  renderer_rx, renderer_ry, mapa_read, wr_en, wr_x, wr_y, wr_tile,
      output mapa_R, mapa_G, mapa_B, wr_ready, busy
   );

endinterface
`default_nettype wire

// File: rtl/mapa_ram.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mapa_ram                                                     |
// | Purpose  : Simple dual-port tile store, one synchronous write port and  |
// |            one synchronous read port, read-before-write on collision.   |
// | Ports    : clk; i_we, i_waddr, i_wdata (write); i_raddr -> o_rdata.     |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module mapa_ram #(
   parameter int DEPTH  = 1200,
   parameter int ADDR_W = 11,
   parameter int DATA_W = 3
) (
   input  wire logic              clk,
   input  wire logic              i_we,
   input  wire logic [ADDR_W-1:0] i_waddr,
   input  wire logic [DATA_W-1:0] i_wdata,
   input  wire logic [ADDR_W-1:0] i_raddr,
   output logic      [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Both ports in one block with non-blocking updates: a read of the cell
   // being written in the same cycle returns the previous contents.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      o_rdata <= r_mem[i_raddr];
   end

endmodule
`default_nettype wire

// File: rtl/mapa.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mapa                                                         |
// | Purpose  : 40x30 tile map for the renderer. After reset a sweep paints  |
// |            a wall border around an empty interior (1200 cycles); then   |
// |            it serves 1-cycle registered colour reads and cell writes.   |
// | Ports    : clk, reset (sync, active-high); bus (mapa_if.slave).         |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module mapa
   import mapa_pkg::*;
(
   input wire logic clk,
   input wire logic reset,
   mapa_if.slave    bus
);

   state_t            r_state;
   logic [ADDR_W-1:0] r_idx;
   logic [5:0]        r_col;
   logic [4:0]        r_row;
   logic              r_busy;
   logic              r_wr_ready;
   logic              r_rd_valid;

   logic              w_rd_in_range;
   logic              w_wr_in_range;
   logic              w_border;
   logic [ADDR_W-1:0] w_raddr;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [TILE_W-1:0] w_wdata;
   logic [TILE_W-1:0] w_rd_tile;
   logic [COLOUR_W-1:0] w_colour;

   assign w_rd_in_range = coord_in_range(bus.renderer_rx, bus.renderer_ry);
   assign w_wr_in_range = coord_in_range(bus.wr_x, bus.wr_y);

   // Sweep position is tracked as row/column alongside the linear index so
   // the border test needs no divider.
   assign w_border = (r_row == 5'd0) || (r_row == LAST_ROW) ||
                     (r_col == 6'd0) || (r_col == LAST_COL);

   // Out-of-range coordinates park the read on cell 0; the result is masked.
   assign w_raddr = w_rd_in_range ?
                    cell_addr(bus.renderer_rx[5:0], bus.renderer_ry[4:0]) : '0;

   // Write port: owned by the sweep in INIT, by game logic in RUN.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_idx;
      w_wdata = TILE_EMPTY;
      if (r_state == ST_INIT) begin
         w_we    = 1'b1;
         w_wdata = w_border ? TILE_WALL : TILE_EMPTY;
      end else if (bus.wr_en && w_wr_in_range) begin
         w_we    = 1'b1;
         w_waddr = cell_addr(bus.wr_x[5:0], bus.wr_y[4:0]);
         w_wdata = bus.wr_tile;
      end
   end

   mapa_ram #(
      .DEPTH  (CELLS),
      .ADDR_W (ADDR_W),
      .DATA_W (TILE_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_rd_tile)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_INIT;
         r_idx      <= '0;
         r_col      <= '0;
         r_row      <= '0;
         r_busy     <= 1'b1;
         r_wr_ready <= 1'b0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         case (r_state)
            ST_INIT: begin
               r_idx <= r_idx + 11'd1;
               if (r_col == LAST_COL) begin
                  r_col <= '0;
                  r_row <= r_row + 5'd1;
               end else begin
                  r_col <= r_col + 6'd1;
               end
               if (r_idx == LAST_CELL) begin
                  r_state    <= ST_RUN;
                  r_busy     <= 1'b0;
                  r_wr_ready <= 1'b1;
               end
            end
            ST_RUN: begin
               // Qualifies the RAM output register captured on this edge.
               r_rd_valid <= bus.mapa_read && w_rd_in_range;
            end
            default: begin
               r_state <= ST_INIT;
            end
         endcase
      end
   end

   // Colour depends only on registers (RAM output + valid flag).
   assign w_colour   = r_rd_valid ? tile_colour(w_rd_tile) : '0;
   assign bus.mapa_R   = w_colour[5:4];
   assign bus.mapa_G   = w_colour[3:2];
   assign bus.mapa_B   = w_colour[1:0];
   assign bus.busy     = r_busy;
   assign bus.wr_ready = r_wr_ready;

endmodule
`default_nettype wire

// File: tb/tb_mapa.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_mapa                                                      |
// | Purpose  : Self-checking bench for mapa: behavioural map model with a   |
// |            per-cycle compare, plus literal directed expectations.       |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_mapa;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mapa_if bus ();

   mapa dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [5:0] pal [8] = '{6'b000000, 6'b101010, 6'b001100, 6'b110000,
                           6'b111100, 6'b000011, 6'b110011, 6'b111111};

   // Model: map contents after the sweep, and cycles of sweep remaining.
   logic [2:0] model [1200];
   int         remaining = 0;
   logic       model_valid = 1'b0;
   logic [5:0] exp_col = '0;
   logic       exp_busy = 1'b1;
   logic       exp_ready = 1'b0;

   wire [5:0] dut_col = {bus.mapa_R, bus.mapa_G, bus.mapa_B};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         for (int y = 0; y < 30; y++)
            for (int x = 0; x < 40; x++)
               model[y*40 + x] <= (y == 0 || y == 29 || x == 0 || x == 39) ? 3'd1 : 3'd0;
         remaining   <= 1200;
         model_valid <= 1'b1;
         exp_col     <= '0;
         exp_busy    <= 1'b1;
         exp_ready   <= 1'b0;
      end else if (model_valid) begin
         if (remaining > 0) begin
            remaining <= remaining - 1;
            exp_col   <= '0;
            exp_busy  <= (remaining > 1);
            exp_ready <= !(remaining > 1);
         end else begin
            if (bus.mapa_read && bus.renderer_rx < 40 && bus.renderer_ry < 30)
               exp_col <= pal[model[int'(bus.renderer_ry)*40 + int'(bus.renderer_rx)]];
            else
               exp_col <= '0;
            if (bus.wr_en && bus.wr_x < 40 && bus.wr_y < 30)
               model[int'(bus.wr_y)*40 + int'(bus.wr_x)] <= bus.wr_tile;
         end
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         check("busy", 32'(bus.busy), 32'(exp_busy));
         check("wr_ready", 32'(bus.wr_ready), 32'(exp_ready));
         check("colour", 32'(dut_col), 32'(exp_col));
      end
   end

   task automatic idle();
      bus.mapa_read   = 1'b0;
      bus.renderer_rx = '0;
      bus.renderer_ry = '0;
      bus.wr_en       = 1'b0;
      bus.wr_x        = '0;
      bus.wr_y        = '0;
      bus.wr_tile     = '0;
   endtask

   task automatic rand_cycle();
      bus.mapa_read   = ($urandom_range(0, 9) != 0);
      bus.renderer_rx = 10'($urandom_range(0, 44));
      bus.renderer_ry = 10'($urandom_range(0, 33));
      bus.wr_en       = ($urandom_range(0, 2) == 0);
      bus.wr_x        = 10'($urandom_range(0, 44));
      bus.wr_y        = 10'($urandom_range(0, 33));
      bus.wr_tile     = 3'($urandom_range(0, 7));
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      idle();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_init(input string name);
      int n = 0;
      while (bus.busy === 1'b1 && n < 1300) begin
         rand_cycle();
         n++;
      end
      check(name, 32'(n), 32'd1200);
      idle();
   endtask

   task automatic rd_check(input int x, input int y, input logic [5:0] exp, input string name);
      bus.mapa_read   = 1'b1;
      bus.renderer_rx = 10'(x);
      bus.renderer_ry = 10'(y);
      bus.wr_en       = 1'b0;
      @(negedge clk);
      check(name, 32'(dut_col), 32'(exp));
      idle();
   endtask

   task automatic wr(input int x, input int y, input logic [2:0] t);
      bus.wr_en   = 1'b1;
      bus.wr_x    = 10'(x);
      bus.wr_y    = 10'(y);
      bus.wr_tile = t;
      @(negedge clk);
      idle();
   endtask

   initial begin
      idle();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset_busy", 32'(bus.busy), 32'd1);
      check("reset_ready", 32'(bus.wr_ready), 32'd0);
      check("reset_colour", 32'(dut_col), 32'd0);

      wait_init("init_cycles");
      check("run_busy", 32'(bus.busy), 32'd0);
      check("run_ready", 32'(bus.wr_ready), 32'd1);

      rd_check(0, 0, 6'b101010, "rd_0_0");
      rd_check(39, 29, 6'b101010, "rd_39_29");
      rd_check(5, 0, 6'b101010, "rd_5_0");
      rd_check(5, 5, 6'b000000, "rd_5_5");

      wr(10, 12, 3'd2);
      rd_check(10, 12, 6'b001100, "rd_after_wr");
      // Same-cycle write and read of one cell returns the old tile.
      bus.wr_en = 1'b1; bus.wr_x = 10'd10; bus.wr_y = 10'd12; bus.wr_tile = 3'd3;
      bus.mapa_read = 1'b1; bus.renderer_rx = 10'd10; bus.renderer_ry = 10'd12;
      @(negedge clk);
      check("rbw_old", 32'(dut_col), 32'b001100);
      idle();
      rd_check(10, 12, 6'b110000, "rbw_new");

      rd_check(40, 0, 6'b000000, "rd_x_oob");
      rd_check(0, 30, 6'b000000, "rd_y_oob");
      bus.mapa_read = 1'b0; bus.renderer_rx = 10'd10; bus.renderer_ry = 10'd12;
      @(negedge clk);
      check("rd_strobe_low", 32'(dut_col), 32'd0);
      idle();
      wr(40, 5, 3'd7);
      rd_check(0, 6, 6'b101010, "oob_wr_no_alias");
      rd_check(39, 5, 6'b101010, "oob_wr_row5");

      for (int i = 0; i < 1500; i++) rand_cycle();
      idle();

      wr(7, 7, 3'd4);
      rd_check(7, 7, 6'b111100, "item_written");
      pulse_reset();
      for (int i = 0; i < 600; i++) rand_cycle();
      pulse_reset();
      check("restart_busy", 32'(bus.busy), 32'd1);
      wait_init("reinit_cycles");
      rd_check(7, 7, 6'b000000, "interior_cleared");
      rd_check(0, 15, 6'b101010, "border_restored");

      for (int i = 0; i < 300; i++) rand_cycle();
      idle();
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
